// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader
// Description : Read-side engine for a simple dual-port block RAM with a
//               registered read port (1-cycle read latency). A start command
//               reads `length` words beginning at `base_addr` and streams them
//               out on a valid/ready interface, flagging the final word with
//               m_last. A small output FIFO absorbs the RAM read latency and
//               downstream backpressure so the stream can run at 1 word/cycle.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start, base_addr,   - command strobe and its run parameters
//               length                (sampled only while idle)
//               busy, done          - run in progress / 1-cycle completion
//               ram_rd_en,          - RAM read request and address
//               ram_addr_rd
//               ram_rd_data         - RAM read data, valid 1 cycle after rd_en
//               m_valid, m_data,    - output stream
//               m_last, m_ready
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2**10,
    parameter int OUT_DEPTH  = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW:0]           length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_rd_en,
    output logic [AW-1:0]         ram_addr_rd,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam logic [CW:0]   C_OUT_DEPTH = (CW+1)'(OUT_DEPTH);
    localparam logic [AW-1:0] C_ADDR_MAX  = AW'(DEPTH - 1);
    localparam logic [PW-1:0] C_PTR_MAX   = PW'(OUT_DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  state_q;
    logic [AW-1:0]           addr_q;
    logic [AW:0]             issue_cnt_q;
    logic [AW:0]             beat_cnt_q;
    logic                    pend_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   fifo_mem_q [OUT_DEPTH];
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [CW-1:0]           fifo_cnt_q;

    logic [CW:0]             w_occupancy;
    logic                    w_rd_en;
    logic                    w_push;
    logic                    w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == C_PTR_MAX) ? '0 : p + PW'(1);
    endfunction

    // Words already queued plus the one landing this cycle. A read issued now
    // lands next cycle, so keeping this below OUT_DEPTH guarantees a free slot.
    assign w_occupancy = {1'b0, fifo_cnt_q} + {{CW{1'b0}}, pend_q};
    assign w_rd_en     = (state_q == S_RUN) && (issue_cnt_q != '0) &&
                         (w_occupancy < C_OUT_DEPTH);
    assign w_push      = pend_q;
    assign w_pop       = m_valid && m_ready;

    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign ram_rd_en   = w_rd_en;
    assign ram_addr_rd = addr_q;
    assign m_valid     = (fifo_cnt_q != '0);
    assign m_data      = fifo_mem_q[rd_ptr_q];
    // The FIFO head is always the beat at position beat_cnt_q from the end.
    assign m_last      = m_valid && (beat_cnt_q == (AW+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            pend_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_q      <= base_addr;
                            issue_cnt_q <= length;
                            beat_cnt_q  <= length;
                            state_q     <= S_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_rd_en) begin
                        addr_q      <= (addr_q == C_ADDR_MAX) ? '0 : addr_q + AW'(1);
                        issue_cnt_q <= issue_cnt_q - (AW+1)'(1);
                    end
                    if (w_pop) begin
                        beat_cnt_q <= beat_cnt_q - (AW+1)'(1);
                        if (m_last) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // RAM data for a read issued this cycle arrives next cycle.
            pend_q <= w_rd_en;

            if (w_push) begin
                fifo_mem_q[wr_ptr_q] <= ram_rd_data;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({w_push, w_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_stream_reader
// Description : Directed self-checking bench for bram_stream_reader with a
//               behavioural 1-cycle-latency RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int ODEP  = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          ram_rd_en;
    logic [AW-1:0] ram_addr_rd;
    logic [DW-1:0] ram_rd_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    int checks;
    int failures;

    logic [DW-1:0] mem [DEPTH];

    bram_stream_reader #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .OUT_DEPTH  (ODEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .ram_rd_en   (ram_rd_en),
        .ram_addr_rd (ram_addr_rd),
        .ram_rd_data (ram_rd_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM model.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_addr_rd];
    end

    function automatic logic [DW-1:0] word_at(input int a);
        if (a >= 'h10 && a <= 'h13) return 32'hA0 + 32'(a - 'h10);
        return 32'hD000_0000 | 32'(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: m_ready=1; mode 1: m_ready=0 for cycles 1..15; mode 2: random.
    // poke_k: cycle at which a spurious start is pulsed while busy (0 = none).
    task automatic run(input int base, input int len, input int mode, input int poke_k);
        int issued = 0;
        int beats  = 0;
        int dones  = 0;
        int k      = 1;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [DW-1:0] pd = '0;
        logic rdy;
        base_addr = AW'(base);
        length    = (AW+1)'(len);
        start     = 1'b1;
        m_ready   = 1'b0;
        tick();
        while (k < 2000 && dones == 0) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k > 15);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            m_ready = rdy;
            start   = (k == poke_k);
            if (k == poke_k) begin
                base_addr = AW'(base + 'h100);
                length    = (AW+1)'(3);
            end
            if (mode == 1 && k == 16) chk("stall_reads", issued, ODEP);
            if (ram_rd_en) begin
                chk("rd_addr", ram_addr_rd, (base + issued) % DEPTH);
                issued++;
            end
            if (m_valid) begin
                if (pv && !pr) chk("hold_data", m_data, pd);
                if (rdy) begin
                    chk("data", m_data, word_at((base + beats) % DEPTH));
                    chk("last", m_last, (beats == len - 1));
                    beats++;
                end
            end
            pv = m_valid;
            pr = rdy;
            pd = m_data;
            if (done) begin
                dones++;
            end else begin
                tick();
                k++;
            end
        end
        start = 1'b0;
        if (dones == 0) chk("timeout", 0, 1);
        chk("beats", beats, len);
        chk("issued", issued, len);
        chk("busy_at_done", busy, 0);
        tick();
        chk("done_once", done, 0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        m_ready   = 1'b0;
        base_addr = '0;
        length    = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = word_at(i);

        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_addr", ram_addr_rd, 0);
        chk("rst_data", m_data, 0);
        rst = 1'b0;
        tick();

        // Basic run with exact cycle timing
        base_addr = AW'('h10);
        length    = (AW+1)'(4);
        m_ready   = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("b_rd_en", ram_rd_en, (k <= 4));
            if (k <= 4) chk("b_addr", ram_addr_rd, 'h10 + k - 1);
            chk("b_valid", m_valid, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) chk("b_data", m_data, 32'hA0 + 32'(k - 3));
            chk("b_last", m_last, (k == 6));
            chk("b_done", done, (k == 7));
            chk("b_busy", busy, (k <= 6));
            tick();
        end

        // Address wrap
        run(1022, 4, 0, 0);
        // Backpressure
        run('h30, 16, 1, 0);
        // Random ready with a spurious start while busy
        run('h80, 37, 2, 5);

        // Zero length
        base_addr = AW'('h20);
        length    = '0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("z_done", done, 1);
        for (int k = 0; k < 4; k++) begin
            chk("z_busy", busy, 0);
            chk("z_valid", m_valid, 0);
            chk("z_rd_en", ram_rd_en, 0);
            tick();
            chk("z_done_off", done, 0);
        end

        // Reset mid-run
        base_addr = AW'('h40);
        length    = (AW+1)'(8);
        m_ready   = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("r_beat3_valid", m_valid, 1);
        rst = 1'b1;
        tick();
        chk("r_busy", busy, 0);
        chk("r_done", done, 0);
        chk("r_rd_en", ram_rd_en, 0);
        chk("r_valid", m_valid, 0);
        chk("r_last", m_last, 0);
        chk("r_addr", ram_addr_rd, 0);
        chk("r_data", m_data, 0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("r_late_valid", m_valid, 0);
            chk("r_late_done", done, 0);
        end
        run(0, 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
